// File: rtl/reg_writeback_unit.sv
// ---------------------------------------------------------------------------
// reg_writeback_unit
//
// Purpose:
//   Sole write-side master of the 32x32 register file. It merges two writeback
//   sources into one in-order queue and retires one entry per clock:
//     - source A: the single-cycle pipeline. It is never stalled, so if no
//       slot is free the write is dropped and Overflow is flagged.
//     - source B: the multi-cycle unit, with a valid/ready handshake.
//   It also keeps a pending-destination scoreboard for issued long-latency
//   ops. Queued data that has not yet been written is forwarded to the two
//   read ports.
//
// Ports:
//   Clk, Reset_n             clock (rising edge), async active-low reset
//   A_Valid/A_RW/A_Data      pipeline writeback
//   B_Valid/B_Ready/B_RW/B_Data  multi-cycle writeback handshake
//   Iss_Valid/Iss_RW         long-latency op issue (marks destination pending)
//   RA, RB                   register file read addresses
//   FwdA/FwdA_Data           forwarding hit and value for RA
//   FwdB/FwdB_Data           forwarding hit and value for RB
//   StallA, StallB           read address waits on an unreturned result
//   RegWr/RW/BusW            register file write port (captured at negedge)
//   Overflow                 sticky flag: an A write was lost (queue full)
// ---------------------------------------------------------------------------
module reg_writeback_unit #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              A_Valid,
   input  logic [ADDR_W-1:0] A_RW,
   input  logic [DATA_W-1:0] A_Data,
   input  logic              B_Valid,
   output logic              B_Ready,
   input  logic [ADDR_W-1:0] B_RW,
   input  logic [DATA_W-1:0] B_Data,
   input  logic              Iss_Valid,
   input  logic [ADDR_W-1:0] Iss_RW,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   output logic              FwdA,
   output logic [DATA_W-1:0] FwdA_Data,
   output logic              FwdB,
   output logic [DATA_W-1:0] FwdB_Data,
   output logic              StallA,
   output logic              StallB,
   output logic              RegWr,
   output logic [ADDR_W-1:0] RW,
   output logic [DATA_W-1:0] BusW,
   output logic              Overflow
);

   localparam int PW = $clog2(DEPTH);   // pointer width
   localparam int CW = PW + 1;          // count width, holds 0..DEPTH
   localparam int NREG = 1 << ADDR_W;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

   // Queue storage. Occupancy is tracked by count alone, so the payload
   // needs no reset.
   logic [ADDR_W-1:0] qRw   [DEPTH];
   logic [DATA_W-1:0] qData [DEPTH];

   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     count;
   logic [NREG-1:0]   pending;
   logic [NREG-1:0]   pendingNext;

   logic              pop;
   logic              aReq;
   logic              aPush;
   logic              aDrop;
   logic              bHs;
   logic              bPush;
   logic [CW:0]       freeSpace;
   logic [PW-1:0]     bSlot;
   logic [DATA_W:0]   fwdResA;
   logic [DATA_W:0]   fwdResB;

   // ------------------------------------------------------------------------
   // Push/pop decisions
   // ------------------------------------------------------------------------
   always_comb begin
      pop       = (count != '0);
      // The entry popped on this edge frees its slot for a push on the
      // same edge.
      freeSpace = DEPTH_L - {1'b0, count} + (CW+1)'(pop);
      aReq      = A_Valid && (A_RW != '0);
      aPush     = aReq && (freeSpace != '0);
      aDrop     = aReq && (freeSpace == '0);
      // B takes a slot only after A has been given one, so A stays ahead of B.
      B_Ready   = (freeSpace >= ((CW+1)'(1) + (CW+1)'(aReq)));
      bHs       = B_Valid && B_Ready;
      bPush     = bHs && (B_RW != '0);
      bSlot     = tail + PW'(aPush);
   end

   // ------------------------------------------------------------------------
   // Scoreboard next state. If an issue and a B return hit the same register
   // on the same edge, the issue wins.
   // ------------------------------------------------------------------------
   always_comb begin
      pendingNext = pending;
      if (bHs)
         pendingNext[B_RW] = 1'b0;
      if (Iss_Valid && (Iss_RW != '0))
         pendingNext[Iss_RW] = 1'b1;
      pendingNext[0] = 1'b0;
   end

   // ------------------------------------------------------------------------
   // Queue payload writes
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (aPush) begin
         qRw[tail]   <= A_RW;
         qData[tail] <= A_Data;
      end
      if (bPush) begin
         qRw[bSlot]   <= B_RW;
         qData[bSlot] <= B_Data;
      end
   end

   // ------------------------------------------------------------------------
   // Control state and register file write port
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         pending  <= '0;
         RegWr    <= 1'b0;
         RW       <= '0;
         BusW     <= '0;
         Overflow <= 1'b0;
      end else begin
         head    <= head + PW'(pop);
         tail    <= tail + PW'(aPush) + PW'(bPush);
         count   <= count - CW'(pop) + CW'(aPush) + CW'(bPush);
         pending <= pendingNext;
         if (pop) begin
            RegWr <= 1'b1;
            RW    <= qRw[head];
            BusW  <= qData[head];
         end else begin
            RegWr <= 1'b0;
         end
         if (aDrop)
            Overflow <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Forwarding lookup. Queue entries are searched newest to oldest, then
   // the output stage, so the newest value always wins. Bit DATA_W is the
   // hit flag.
   // ------------------------------------------------------------------------
   function automatic logic [DATA_W:0] fwdLookup(input logic [ADDR_W-1:0] ra);
      logic [DATA_W:0] res;
      logic            found;
      logic [PW-1:0]   idx;
      res   = '0;
      found = 1'b0;
      if (ra != '0) begin
         for (int i = 0; i < DEPTH; i++) begin
            idx = tail - PW'(i) - PW'(1);
            if (!found && (CW'(i) < count) && (qRw[idx] == ra)) begin
               found = 1'b1;
               res   = {1'b1, qData[idx]};
            end
         end
         if (!found && RegWr && (RW == ra))
            res = {1'b1, BusW};
      end
      return res;
   endfunction

   always_comb begin
      fwdResA = fwdLookup(RA);
      fwdResB = fwdLookup(RB);
   end

   assign FwdA      = fwdResA[DATA_W];
   assign FwdA_Data = fwdResA[DATA_W-1:0];
   assign FwdB      = fwdResB[DATA_W];
   assign FwdB_Data = fwdResB[DATA_W-1:0];

   assign StallA = pending[RA] && (RA != '0);
   assign StallB = pending[RB] && (RB != '0);

endmodule

// File: tb/tb_reg_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback_unit
//
// Directed scenarios followed by a randomized run. Expected values come from
// a queue-based reference model of the writeback rules.
// ---------------------------------------------------------------------------
module tb_reg_writeback_unit;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              Clk = 1'b0;
   logic              Reset_n;
   logic              A_Valid;
   logic [ADDR_W-1:0] A_RW;
   logic [DATA_W-1:0] A_Data;
   logic              B_Valid;
   logic              B_Ready;
   logic [ADDR_W-1:0] B_RW;
   logic [DATA_W-1:0] B_Data;
   logic              Iss_Valid;
   logic [ADDR_W-1:0] Iss_RW;
   logic [ADDR_W-1:0] RA;
   logic [ADDR_W-1:0] RB;
   logic              FwdA;
   logic [DATA_W-1:0] FwdA_Data;
   logic              FwdB;
   logic [DATA_W-1:0] FwdB_Data;
   logic              StallA;
   logic              StallB;
   logic              RegWr;
   logic [ADDR_W-1:0] RW;
   logic [DATA_W-1:0] BusW;
   logic              Overflow;

   always #5 Clk = ~Clk;

   reg_writeback_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .A_Valid(A_Valid), .A_RW(A_RW), .A_Data(A_Data),
      .B_Valid(B_Valid), .B_Ready(B_Ready), .B_RW(B_RW), .B_Data(B_Data),
      .Iss_Valid(Iss_Valid), .Iss_RW(Iss_RW),
      .RA(RA), .RB(RB),
      .FwdA(FwdA), .FwdA_Data(FwdA_Data), .FwdB(FwdB), .FwdB_Data(FwdB_Data),
      .StallA(StallA), .StallB(StallB),
      .RegWr(RegWr), .RW(RW), .BusW(BusW), .Overflow(Overflow)
   );

   int tests  = 0;
   int failed = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [ADDR_W-1:0] rw;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t              mq[$];
   logic              mWr;
   logic [ADDR_W-1:0] mRw;
   logic [DATA_W-1:0] mData;
   bit                mPend[32];
   logic              mOvf;

   task automatic mReset();
      mq.delete();
      mWr = 1'b0; mRw = '0; mData = '0; mOvf = 1'b0;
      foreach (mPend[i]) mPend[i] = 1'b0;
   endtask

   function automatic int mFree();
      return DEPTH - mq.size() + ((mq.size() != 0) ? 1 : 0);
   endfunction

   function automatic logic mBReady();
      int need;
      need = 1 + ((A_Valid && A_RW != 0) ? 1 : 0);
      return (mFree() >= need);
   endfunction

   function automatic logic [DATA_W:0] mFwd(input logic [ADDR_W-1:0] ra);
      if (ra == 0) return '0;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].rw == ra) return {1'b1, mq[i].d};
      if (mWr && mRw == ra) return {1'b1, mData};
      return '0;
   endfunction

   function automatic logic mStall(input logic [ADDR_W-1:0] ra);
      return (ra != 0) && mPend[ra];
   endfunction

   // Advance the model across one rising edge using the current inputs.
   task automatic mStep();
      ent_t e;
      int   fr;
      logic rdy;
      if (!Reset_n) begin
         mReset();
         return;
      end
      fr  = mFree();
      rdy = mBReady();
      if (mq.size() != 0) begin
         e = mq.pop_front();
         mWr = 1'b1; mRw = e.rw; mData = e.d;
      end else begin
         mWr = 1'b0;
      end
      if (A_Valid && A_RW != 0) begin
         if (fr == 0) mOvf = 1'b1;
         else begin e.rw = A_RW; e.d = A_Data; mq.push_back(e); end
      end
      if (B_Valid && rdy && B_RW != 0) begin
         e.rw = B_RW; e.d = B_Data; mq.push_back(e);
      end
      if (B_Valid && rdy) mPend[B_RW] = 1'b0;
      if (Iss_Valid && Iss_RW != 0) mPend[Iss_RW] = 1'b1;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic checkComb();
      logic [DATA_W:0] fa, fb;
      fa = mFwd(RA);
      fb = mFwd(RB);
      check("B_Ready",   64'(B_Ready),   64'(mBReady()));
      check("FwdA",      64'(FwdA),      64'(fa[DATA_W]));
      check("FwdA_Data", 64'(FwdA_Data), 64'(fa[DATA_W-1:0]));
      check("FwdB",      64'(FwdB),      64'(fb[DATA_W]));
      check("FwdB_Data", 64'(FwdB_Data), 64'(fb[DATA_W-1:0]));
      check("StallA",    64'(StallA),    64'(mStall(RA)));
      check("StallB",    64'(StallB),    64'(mStall(RB)));
   endtask

   task automatic checkRegs();
      check("RegWr",    64'(RegWr),    64'(mWr));
      check("RW",       64'(RW),       64'(mRw));
      check("BusW",     64'(BusW),     64'(mData));
      check("Overflow", 64'(Overflow), 64'(mOvf));
   endtask

   // Called at posedge+1 with inputs set: check, clock once, check again.
   task automatic tick();
      #1;
      checkComb();
      mStep();
      @(posedge Clk);
      #1;
      checkRegs();
   endtask

   task automatic clearIn();
      A_Valid = 1'b0; A_RW = '0; A_Data = '0;
      B_Valid = 1'b0; B_RW = '0; B_Data = '0;
      Iss_Valid = 1'b0; Iss_RW = '0;
   endtask

   initial begin
      Reset_n = 1'b0;
      clearIn();
      RA = '0; RB = '0;
      mReset();
      @(posedge Clk);
      #1;

      // Reset state
      tick();
      check("rst_RegWr", 64'(RegWr), 64'd0);
      check("rst_RW", 64'(RW), 64'd0);
      check("rst_BusW", 64'(BusW), 64'd0);
      check("rst_Overflow", 64'(Overflow), 64'd0);
      check("rst_BReady", 64'(B_Ready), 64'd1);
      Reset_n = 1'b1;
      tick();

      // Single A write: one-cycle latency, forwarded while queued
      A_Valid = 1'b1; A_RW = 5'd5; A_Data = 32'h1234; RA = 5'd5;
      #1;
      check("a_noSameCycleFwd", 64'(FwdA), 64'd0);
      tick();
      check("a_notYet", 64'(RegWr), 64'd0);
      clearIn();
      #1;
      check("a_fwdHit", 64'(FwdA), 64'd1);
      check("a_fwdData", 64'(FwdA_Data), 64'h1234);
      tick();
      check("a_RegWr", 64'(RegWr), 64'd1);
      check("a_RW", 64'(RW), 64'd5);
      check("a_BusW", 64'(BusW), 64'h1234);
      tick();
      check("a_oneCycle", 64'(RegWr), 64'd0);

      // A and B on the same edge to the same register: A first, B newest
      A_Valid = 1'b1; A_RW = 5'd3; A_Data = 32'hAAAA;
      B_Valid = 1'b1; B_RW = 5'd3; B_Data = 32'hBBBB;
      #1;
      check("ab_BReady", 64'(B_Ready), 64'd1);
      tick();
      clearIn();
      RA = 5'd3;
      #1;
      check("ab_fwdNewest", 64'(FwdA_Data), 64'hBBBB);
      tick();
      check("ab_first_RW", 64'(RW), 64'd3);
      check("ab_first_BusW", 64'(BusW), 64'hAAAA);
      tick();
      check("ab_second_BusW", 64'(BusW), 64'hBBBB);
      check("ab_second_RegWr", 64'(RegWr), 64'd1);
      tick();

      // Scoreboard: issue, stall until B returns
      Iss_Valid = 1'b1; Iss_RW = 5'd7; RA = 5'd7; RB = 5'd7;
      tick();
      clearIn();
      #1;
      check("sb_stallSet", 64'(StallA), 64'd1);
      tick();
      tick();
      B_Valid = 1'b1; B_RW = 5'd7; B_Data = 32'h77;
      #1;
      check("sb_stallBeforeHs", 64'(StallA), 64'd1);
      tick();
      clearIn();
      #1;
      check("sb_stallCleared", 64'(StallA), 64'd0);
      tick();
      // Issue and return on the same edge: set wins
      Iss_Valid = 1'b1; Iss_RW = 5'd7;
      tick();
      Iss_Valid = 1'b1; Iss_RW = 5'd7;
      B_Valid = 1'b1; B_RW = 5'd7; B_Data = 32'h78;
      tick();
      clearIn();
      #1;
      check("sb_setWins", 64'(StallA), 64'd1);
      B_Valid = 1'b1; B_RW = 5'd7; B_Data = 32'h79;
      tick();
      clearIn();
      #1;
      check("sb_finalClear", 64'(StallA), 64'd0);
      for (int i = 0; i < 4; i++) tick();

      // Saturation: both sources every cycle. free never reaches zero while
      // a pop is in flight, so the model expects Overflow to stay low.
      RA = 5'd10; RB = 5'd20;
      for (int i = 0; i < 10; i++) begin
         A_Valid = 1'b1; A_RW = 5'd10; A_Data = $urandom;
         B_Valid = 1'b1; B_RW = 5'd20; B_Data = $urandom;
         tick();
      end
      #1;
      check("sat_BReadyLow", 64'(B_Ready), 64'd0);
      clearIn();
      for (int i = 0; i < 6; i++) tick();

      // Register 0 writes are dropped
      for (int i = 0; i < 4; i++) begin
         A_Valid = 1'b1; A_RW = '0; A_Data = $urandom;
         B_Valid = 1'b1; B_RW = '0; B_Data = $urandom;
         tick();
         check("zero_noWrite", 64'(RegWr), 64'd0);
      end
      clearIn();
      tick();

      // Asynchronous reset while draining with three entries queued
      Iss_Valid = 1'b1; Iss_RW = 5'd9; RA = 5'd9; RB = 5'd9;
      A_Valid = 1'b1; A_RW = 5'd11; A_Data = 32'h11;
      B_Valid = 1'b1; B_RW = 5'd12; B_Data = 32'h12;
      tick();
      Iss_Valid = 1'b0;
      A_RW = 5'd13; A_Data = 32'h13;
      B_RW = 5'd14; B_Data = 32'h14;
      tick();
      clearIn();
      #1;
      check("ar_stallBefore", 64'(StallA), 64'd1);
      check("ar_drainActive", 64'(RegWr), 64'd1);
      Reset_n = 1'b0;
      #1;
      mReset();
      check("ar_RegWrAsync", 64'(RegWr), 64'd0);
      check("ar_StallA", 64'(StallA), 64'd0);
      check("ar_StallB", 64'(StallB), 64'd0);
      tick();
      Reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("ar_noLeftover", 64'(RegWr), 64'd0);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         A_Valid   = 1'($urandom_range(0, 1));
         A_RW      = 5'($urandom_range(0, 7));
         A_Data    = $urandom;
         B_Valid   = 1'($urandom_range(0, 1));
         B_RW      = 5'($urandom_range(0, 7));
         B_Data    = $urandom;
         Iss_Valid = ($urandom_range(0, 3) == 0);
         Iss_RW    = 5'($urandom_range(0, 7));
         RA        = 5'($urandom_range(0, 7));
         RB        = 5'($urandom_range(0, 7));
         tick();
      end
      clearIn();
      for (int i = 0; i < 6; i++) tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
